// File: rtl/uart_fifo_bridge.sv
// Buffering bridge between the CPU peripheral bus and the UART core.
//
// TX side: software pushes bytes with tx_wr/tx_data into a TX FIFO. Whenever the
// UART transmitter is idle the head byte is presented on uart_data_in with a
// one-cycle uart_enable_write load pulse.
// RX side: each byte the UART reports via uart_data_avail is acknowledged with a
// one-cycle uart_enable_read pulse and, space permitting, pushed into an RX FIFO.
// Software pops with rx_rd; rx_data shows the head entry (fall-through).
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   tx_wr, tx_data           TX push strobe and byte
//   rx_rd, rx_data           RX pop strobe and head byte (0x00 when empty)
//   tx_full, tx_empty        TX FIFO status
//   rx_empty                 RX FIFO status
//   tx_count, rx_count       FIFO occupancy (0..DEPTH)
//   tx_overflow, rx_overrun  sticky error flags, cleared by err_clr
//   irq_mask, irq            bit0: RX not empty, bit1: TX empty
//   uart_*                   UART core handshake (load pulse, busy, data, ack)
module uart_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_wr,
  input  logic [7:0]            tx_data,
  input  logic                  rx_rd,
  output logic [7:0]            rx_data,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  tx_overflow,
  output logic                  rx_overrun,
  input  logic                  err_clr,
  input  logic [1:0]            irq_mask,
  output logic                  irq,
  output logic [7:0]            uart_data_in,
  output logic                  uart_enable_write,
  input  logic                  uart_busy_write,
  input  logic [7:0]            uart_data_out,
  input  logic                  uart_data_avail,
  output logic                  uart_enable_read
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Storage
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];

  // State
  logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]            uart_din_q, uart_din_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic                  rd_pulse_q, rd_pulse_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic                  rx_orun_q, rx_orun_d;

  // Events
  logic tx_push, tx_pop, tx_full_int, tx_empty_int;
  logic rx_capture, rx_push, rx_pop, rx_full_int, rx_empty_int;

  assign tx_full_int  = (tx_cnt_q == CNT_FULL);
  assign tx_empty_int = (tx_cnt_q == '0);
  assign rx_full_int  = (rx_cnt_q == CNT_FULL);
  assign rx_empty_int = (rx_cnt_q == '0);

  assign tx_push = tx_wr & ~tx_full_int;
  // The wr_pulse_q term forces an idle cycle between loads so the UART has time
  // to raise busy after sampling the previous pulse.
  assign tx_pop  = ~tx_empty_int & ~uart_busy_write & ~wr_pulse_q;

  // rd_pulse_q blocks re-capturing the same byte while avail is still high
  // during the acknowledge cycle.
  assign rx_capture = uart_data_avail & ~rd_pulse_q;
  assign rx_push    = rx_capture & ~rx_full_int;
  assign rx_pop     = rx_rd & ~rx_empty_int;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    uart_din_d = uart_din_q;
    if (tx_pop) uart_din_d = tx_mem[tx_rptr_q];
    wr_pulse_d = tx_pop;
    rd_pulse_d = rx_capture;

    // Set has priority over clear so a same-cycle error is never lost.
    tx_ovf_d = tx_ovf_q;
    if (tx_wr && tx_full_int) begin
      tx_ovf_d = 1'b1;
    end else if (err_clr) begin
      tx_ovf_d = 1'b0;
    end

    rx_orun_d = rx_orun_q;
    if (rx_capture && rx_full_int) begin
      rx_orun_d = 1'b1;
    end else if (err_clr) begin
      rx_orun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      uart_din_q <= 8'h00;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_orun_q  <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      uart_din_q <= uart_din_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_orun_q  <= rx_orun_d;
    end
  end

  // Entries are only ever read when the matching count says they are valid,
  // so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    if (rx_push) rx_mem[rx_wptr_q] <= uart_data_out;
  end

  assign rx_data           = rx_empty_int ? 8'h00 : rx_mem[rx_rptr_q];
  assign tx_full           = tx_full_int;
  assign tx_empty          = tx_empty_int;
  assign rx_empty          = rx_empty_int;
  assign tx_count          = tx_cnt_q;
  assign rx_count          = rx_cnt_q;
  assign tx_overflow       = tx_ovf_q;
  assign rx_overrun        = rx_orun_q;
  assign irq               = (irq_mask[0] & ~rx_empty_int) | (irq_mask[1] & tx_empty_int);
  assign uart_data_in      = uart_din_q;
  assign uart_enable_write = wr_pulse_q;
  assign uart_enable_read  = rd_pulse_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: a queue-based reference model is
// compared against the DUT on every falling edge, and directed scenarios pin
// the observable behaviour with hand-computed literal expectations.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       tx_full, tx_empty, rx_empty;
  logic [4:0] rx_count, tx_count;
  logic       tx_overflow, rx_overrun;
  logic       err_clr = 1'b0;
  logic [1:0] irq_mask = 2'b00;
  logic       irq;
  logic [7:0] uart_data_in;
  logic       uart_enable_write;
  logic       uart_busy_write = 1'b0;
  logic [7:0] uart_data_out = 8'h00;
  logic       uart_data_avail = 1'b0;
  logic       uart_enable_read;

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .tx_wr             (tx_wr),
    .tx_data           (tx_data),
    .rx_rd             (rx_rd),
    .rx_data           (rx_data),
    .tx_full           (tx_full),
    .tx_empty          (tx_empty),
    .rx_empty          (rx_empty),
    .rx_count          (rx_count),
    .tx_count          (tx_count),
    .tx_overflow       (tx_overflow),
    .rx_overrun        (rx_overrun),
    .err_clr           (err_clr),
    .irq_mask          (irq_mask),
    .irq               (irq),
    .uart_data_in      (uart_data_in),
    .uart_enable_write (uart_enable_write),
    .uart_busy_write   (uart_busy_write),
    .uart_data_out     (uart_data_out),
    .uart_data_avail   (uart_data_avail),
    .uart_enable_read  (uart_enable_read)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain byte queues plus the handshake pulse flags.
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  logic [7:0] m_din;
  logic       m_ew, m_er, m_ovf, m_orun;
  logic       m_tx_was_full, m_rx_was_full, m_issue, m_capture;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_txq.delete();
      m_rxq.delete();
      m_din  = 8'h00;
      m_ew   = 1'b0;
      m_er   = 1'b0;
      m_ovf  = 1'b0;
      m_orun = 1'b0;
    end else begin
      m_tx_was_full = (m_txq.size() == 16);
      m_rx_was_full = (m_rxq.size() == 16);
      m_issue   = (m_txq.size() != 0) && !uart_busy_write && !m_ew;
      m_capture = uart_data_avail && !m_er;
      if (m_issue) m_din = m_txq.pop_front();
      m_ew = m_issue;
      if (tx_wr && !m_tx_was_full) m_txq.push_back(tx_data);
      if (tx_wr && m_tx_was_full) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (rx_rd && m_rxq.size() != 0) m_rxq.delete(0);
      if (m_capture && !m_rx_was_full) m_rxq.push_back(uart_data_out);
      if (m_capture && m_rx_was_full) m_orun = 1'b1;
      else if (err_clr) m_orun = 1'b0;
      m_er = m_capture;
    end
  end

  // Observed UART-side traffic, for the directed scenarios.
  logic [7:0] obs_tx[$];
  int         ack_cnt = 0;

  always @(negedge clk) begin
    check("tx_count", 32'(tx_count), 32'(m_txq.size()));
    check("rx_count", 32'(rx_count), 32'(m_rxq.size()));
    check("tx_full", 32'(tx_full), 32'(m_txq.size() == 16));
    check("tx_empty", 32'(tx_empty), 32'(m_txq.size() == 0));
    check("rx_empty", 32'(rx_empty), 32'(m_rxq.size() == 0));
    check("rx_data", 32'(rx_data), 32'((m_rxq.size() != 0) ? m_rxq[0] : 8'h00));
    check("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    check("rx_overrun", 32'(rx_overrun), 32'(m_orun));
    check("irq", 32'(irq),
          32'((irq_mask[0] && m_rxq.size() != 0) || (irq_mask[1] && m_txq.size() == 0)));
    check("uart_enable_write", 32'(uart_enable_write), 32'(m_ew));
    check("uart_data_in", 32'(uart_data_in), 32'(m_din));
    check("uart_enable_read", 32'(uart_enable_read), 32'(m_er));
    if (uart_enable_write) obs_tx.push_back(uart_data_in);
    if (uart_enable_read) ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    tx_data = b;
    tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    uart_data_out = b;
    uart_data_avail = 1'b1;
    tick();
    uart_data_avail = 1'b0;
    tick();
  endtask

  task automatic rx_read();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag, input logic exp_irq);
    check({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
    check({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
    check({tag, "_tx_full"}, 32'(tx_full), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    check({tag, "_tx_overflow"}, 32'(tx_overflow), 32'd0);
    check({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
    check({tag, "_enable_write"}, 32'(uart_enable_write), 32'd0);
    check({tag, "_enable_read"}, 32'(uart_enable_read), 32'd0);
    check({tag, "_data_in"}, 32'(uart_data_in), 32'h00);
    check({tag, "_irq"}, 32'(irq), 32'(exp_irq));
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) tick();
    check_reset_values("reset", 1'b0);
    reset = 1'b0;
    tick();

    // Single byte into an idle UART.
    obs_tx.delete();
    tx_write(8'h55);
    repeat (4) tick();
    check("single_pulses", 32'(obs_tx.size()), 32'd1);
    check("single_data", 32'((obs_tx.size() > 0) ? obs_tx[0] : 8'hEE), 32'h55);
    check("single_tx_empty", 32'(tx_empty), 32'd1);

    // Fill TX while busy, overflow, then drain in order.
    obs_tx.delete();
    uart_busy_write = 1'b1;
    for (int i = 1; i <= 16; i++) tx_write(8'(i));
    check("fill_tx_full", 32'(tx_full), 32'd1);
    check("fill_tx_count", 32'(tx_count), 32'd16);
    tx_write(8'h11);
    check("ovf_flag", 32'(tx_overflow), 32'd1);
    check("ovf_tx_count", 32'(tx_count), 32'd16);
    uart_busy_write = 1'b0;
    repeat (40) tick();
    check("drain_pulses", 32'(obs_tx.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 32'((obs_tx.size() > i) ? obs_tx[i] : 8'hEE), 32'(i + 1));
    end
    check("drain_tx_empty", 32'(tx_empty), 32'd1);
    pulse_err_clr();
    check("ovf_cleared", 32'(tx_overflow), 32'd0);

    // data_avail held two cycles gives one acknowledge.
    ack_cnt = 0;
    uart_data_out = 8'hA7;
    uart_data_avail = 1'b1;
    repeat (2) tick();
    uart_data_avail = 1'b0;
    tick();
    check("hold_acks", 32'(ack_cnt), 32'd1);
    check("hold_rx_count", 32'(rx_count), 32'd1);
    check("hold_rx_data", 32'(rx_data), 32'hA7);
    rx_read();
    check("hold_drained", 32'(rx_empty), 32'd1);

    // 17 bytes without reads: overrun, then drain 16 in order.
    ack_cnt = 0;
    for (int i = 0; i < 17; i++) rx_deliver(8'(8'h30 + i));
    check("orun_rx_count", 32'(rx_count), 32'd16);
    check("orun_flag", 32'(rx_overrun), 32'd1);
    check("orun_acks", 32'(ack_cnt), 32'd17);
    pulse_err_clr();
    check("orun_cleared", 32'(rx_overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check("orun_drain_data", 32'(rx_data), 32'(8'h30 + i));
      rx_read();
    end
    check("orun_drain_empty", 32'(rx_empty), 32'd1);
    check("orun_drain_data0", 32'(rx_data), 32'h00);

    // Simultaneous capture and pop at count 3.
    for (int i = 0; i < 3; i++) rx_deliver(8'(8'h60 + i));
    uart_data_out = 8'h63;
    uart_data_avail = 1'b1;
    rx_rd = 1'b1;
    tick();
    uart_data_avail = 1'b0;
    rx_rd = 1'b0;
    tick();
    check("simul_rx_count", 32'(rx_count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      check("simul_order", 32'(rx_data), 32'(8'h60 + i));
      rx_read();
    end

    // Pointer wrap over 40 bytes, two in flight.
    rx_deliver(8'h01);
    for (int i = 0; i < 40; i++) begin
      rx_deliver(8'(i * 7 + 8));
      check("wrap_data", 32'(rx_data), 32'((i == 0) ? 8'h01 : 8'((i - 1) * 7 + 8)));
      rx_read();
    end
    check("wrap_last", 32'(rx_data), 32'(8'(39 * 7 + 8)));
    rx_read();
    check("wrap_empty", 32'(rx_empty), 32'd1);

    // Interrupt masking.
    irq_mask = 2'b01;
    tick();
    check("irq_rx_only_empty", 32'(irq), 32'd0);
    rx_deliver(8'h5A);
    check("irq_rx_only_data", 32'(irq), 32'd1);
    rx_read();
    check("irq_rx_only_drained", 32'(irq), 32'd0);
    irq_mask = 2'b10;
    tick();
    check("irq_tx_empty", 32'(irq), 32'd1);
    uart_busy_write = 1'b1;
    tx_write(8'h77);
    check("irq_tx_pending", 32'(irq), 32'd0);
    uart_busy_write = 1'b0;
    repeat (3) tick();
    check("irq_tx_sent", 32'(irq), 32'd1);

    // Reset in the middle of a burst.
    irq_mask = 2'b11;
    uart_busy_write = 1'b1;
    for (int i = 0; i < 5; i++) tx_write(8'(8'hC0 + i));
    rx_deliver(8'hD0);
    rx_deliver(8'hD1);
    check("burst_tx_count", 32'(tx_count), 32'd5);
    check("burst_rx_count", 32'(rx_count), 32'd2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset", 1'b1);
    tick();
    reset = 1'b0;
    uart_busy_write = 1'b0;
    repeat (3) tick();
    check("post_reset_tx_empty", 32'(tx_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
